// File: rtl/dbus_sram_bridge.sv
// dbus_sram_bridge
//   Takes load/store requests from the commit stage's data-memory port and
//   registers them in a one-entry hold register. With MAP_KSEG=1 it folds
//   kseg0/kseg1 addresses down to physical. It then drives them onto an
//   SRAM-like req/addr_ok/data_ok bus.
//   It counts accepted-but-unanswered requests. On a flush, every live request
//   is marked for discard, so its response is swallowed and never returned
//   upstream.
//
// Ports
//   clk, reset(active-low, async), flush
//   up_req/up_is_write/up_size/up_addr/up_wdata/up_write_en   upstream request
//   up_addr_ok, up_data_ok, up_rdata                            upstream handshake
//   sram_req/sram_wr/sram_size/sram_addr/sram_wdata/sram_wstrb  downstream request
//   sram_addr_ok, sram_data_ok, sram_rdata                      downstream handshake
//   protocol_err                                                sticky: data_ok with nothing in flight
module dbus_sram_bridge #(
  parameter int OUTSTANDING = 2,
  parameter bit MAP_KSEG    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        up_req,
  input  logic        up_is_write,
  input  logic [1:0]  up_size,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  input  logic [3:0]  up_write_en,
  output logic        up_addr_ok,
  output logic        up_data_ok,
  output logic [31:0] up_rdata,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_wstrb,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,
  output logic        protocol_err
);

  localparam logic [1:0] OUT_MAX = 2'(OUTSTANDING);

  // kseg0 (100) and kseg1 (101) both map onto the low 512 MB of physical space.
  function automatic logic [31:0] translate(input logic [31:0] a);
    if (MAP_KSEG && (a[31:30] == 2'b10)) return {3'b000, a[28:0]};
    return a;
  endfunction

  logic        hold_valid_q, hold_valid_d;
  logic        hold_wr_q,    hold_wr_d;
  logic [1:0]  hold_size_q,  hold_size_d;
  logic [31:0] hold_addr_q,  hold_addr_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;
  logic [3:0]  hold_wstrb_q, hold_wstrb_d;
  logic [1:0]  cnt_q,  cnt_d;
  logic [1:0]  drop_q, drop_d;
  logic        perr_q, perr_d;

  logic accept;
  logic resp_live;

  always_comb begin
    accept    = up_req & ~hold_valid_q & ~flush & (cnt_q < OUT_MAX);
    resp_live = sram_data_ok & (cnt_q != 2'd0);

    hold_valid_d = hold_valid_q;
    hold_wr_d    = hold_wr_q;
    hold_size_d  = hold_size_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_wstrb_d = hold_wstrb_q;
    cnt_d        = cnt_q + {1'b0, accept} - {1'b0, resp_live};
    drop_d       = drop_q;
    perr_d       = perr_q | (sram_data_ok & (cnt_q == 2'd0));

    // Accept only happens with the hold register empty, so it never races the
    // addr_ok release below.
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_wr_d    = up_is_write;
      hold_size_d  = up_size;
      hold_addr_d  = translate(up_addr);
      hold_wdata_d = up_wdata;
      hold_wstrb_d = up_is_write ? up_write_en : 4'b0000;
    end else if (hold_valid_q && sram_addr_ok) begin
      hold_valid_d = 1'b0;
    end

    // Flush turns every request still live after this cycle's response into
    // one to discard. A request already on the bus is left in place, because
    // the bus cannot withdraw it.
    if (flush) begin
      drop_d = cnt_q - {1'b0, resp_live};
    end else if (resp_live && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end

    up_addr_ok = accept;
    up_data_ok = resp_live & (drop_q == 2'd0) & ~flush;
    up_rdata   = up_data_ok ? sram_rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      hold_wr_q    <= 1'b0;
      hold_size_q  <= 2'd0;
      hold_addr_q  <= 32'h0;
      hold_wdata_q <= 32'h0;
      hold_wstrb_q <= 4'h0;
      cnt_q        <= 2'd0;
      drop_q       <= 2'd0;
      perr_q       <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_wr_q    <= hold_wr_d;
      hold_size_q  <= hold_size_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_wstrb_q <= hold_wstrb_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      perr_q       <= perr_d;
    end
  end

  assign sram_req     = hold_valid_q;
  assign sram_wr      = hold_wr_q;
  assign sram_size    = hold_size_q;
  assign sram_addr    = hold_addr_q;
  assign sram_wdata   = hold_wdata_q;
  assign sram_wstrb   = hold_wstrb_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_dbus_sram_bridge.sv
module tb_dbus_sram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        up_req, up_is_write;
  logic [1:0]  up_size;
  logic [31:0] up_addr, up_wdata;
  logic [3:0]  up_write_en;
  logic        up_addr_ok, up_data_ok;
  logic [31:0] up_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_sram_bridge #(.OUTSTANDING(2), .MAP_KSEG(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .up_req(up_req), .up_is_write(up_is_write), .up_size(up_size),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_write_en(up_write_en),
    .up_addr_ok(up_addr_ok), .up_data_ok(up_data_ok), .up_rdata(up_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .protocol_err(protocol_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // combinational outputs are sampled #1 later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_up(input logic req, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    up_req = req; up_is_write = wr; up_size = sz; up_addr = a; up_wdata = wd; up_write_en = we;
  endtask

  // Accept a load, then let it go out on the bus with immediate addr_ok.
  task automatic issue_load(input logic [31:0] a);
    drive_up(1'b1, 1'b0, 2'd2, a, 32'h0, 4'hF);
    #1 check_val("issue_accept", {31'b0, up_addr_ok}, 32'd1);
    step();
    drive_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    sram_addr_ok = 1'b1;
    step();
    sram_addr_ok = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd, input logic exp_ok, input string tag);
    sram_data_ok = 1'b1; sram_rdata = rd;
    #1 check_val(tag, {31'b0, up_data_ok}, {31'b0, exp_ok});
    if (exp_ok) check_val({tag, "_rdata"}, up_rdata, rd);
    step();
    sram_data_ok = 1'b0; sram_rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    drive_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0;
    repeat (3) step();
    #1;
    check_val("rst_sram_req", {31'b0, sram_req}, 32'd0);
    check_val("rst_sram_addr", sram_addr, 32'h0);
    check_val("rst_perr", {31'b0, protocol_err}, 32'd0);
    check_val("rst_data_ok", {31'b0, up_data_ok}, 32'd0);
    reset = 1'b1;
    step();

    // Load through kseg0: accepted in N, on the bus in N+1, answered in N+3.
    drive_up(1'b1, 1'b0, 2'd2, 32'h8000_1004, 32'h0, 4'hF);
    #1 check_val("ld_accept", {31'b0, up_addr_ok}, 32'd1);
    check_val("ld_no_comb_req", {31'b0, sram_req}, 32'd0);
    step();
    drive_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    #1 check_val("ld_sram_req", {31'b0, sram_req}, 32'd1);
    check_val("ld_addr", sram_addr, 32'h0000_1004);
    check_val("ld_wstrb", {28'b0, sram_wstrb}, 32'h0);
    check_val("ld_wr", {31'b0, sram_wr}, 32'd0);
    check_val("ld_size", {30'b0, sram_size}, 32'd2);
    sram_addr_ok = 1'b1;
    step();
    sram_addr_ok = 1'b0;
    #1 check_val("ld_req_drop", {31'b0, sram_req}, 32'd0);
    step();
    respond(32'hDEAD_BEEF, 1'b1, "ld_resp");
    #1 check_val("ld_resp_once", {31'b0, up_data_ok}, 32'd0);

    // Store through kseg1 with addr_ok withheld for 5 cycles.
    drive_up(1'b1, 1'b1, 2'd0, 32'hA000_0010, 32'h1122_3344, 4'b0100);
    #1 check_val("st_accept", {31'b0, up_addr_ok}, 32'd1);
    step();
    drive_up(1'b1, 1'b0, 2'd2, 32'h0040_0000, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val($sformatf("st_stall_addr%0d", i), sram_addr, 32'h0000_0010);
      check_val($sformatf("st_stall_strb%0d", i), {28'b0, sram_wstrb}, 32'h4);
      check_val($sformatf("st_stall_wr%0d", i), {31'b0, sram_wr}, 32'd1);
      check_val($sformatf("st_stall_wd%0d", i), sram_wdata, 32'h1122_3344);
      check_val($sformatf("st_stall_aok%0d", i), {31'b0, up_addr_ok}, 32'd0);
      step();
    end
    sram_addr_ok = 1'b1;
    #1 check_val("st_release_aok", {31'b0, up_addr_ok}, 32'd0);
    step();
    sram_addr_ok = 1'b0;
    #1 check_val("kuseg_accept", {31'b0, up_addr_ok}, 32'd1);
    step();
    drive_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    #1 check_val("kuseg_addr", sram_addr, 32'h0040_0000);
    sram_addr_ok = 1'b1;
    step();
    sram_addr_ok = 1'b0;
    respond(32'h0, 1'b1, "st_resp");
    respond(32'h1234_5678, 1'b1, "kuseg_resp");

    // Two loads in flight: a third is held off until a response frees a slot.
    issue_load(32'h0000_1000);
    issue_load(32'h0000_2000);
    drive_up(1'b1, 1'b0, 2'd2, 32'h0000_3000, 32'h0, 4'hF);
    #1 check_val("full_block0", {31'b0, up_addr_ok}, 32'd0);
    step();
    #1 check_val("full_block1", {31'b0, up_addr_ok}, 32'd0);
    sram_data_ok = 1'b1; sram_rdata = 32'h0000_000A;
    #1 check_val("full_block_resp", {31'b0, up_addr_ok}, 32'd0);
    check_val("full_resp_ok", {31'b0, up_data_ok}, 32'd1);
    step();
    sram_data_ok = 1'b0;
    #1 check_val("full_unblock", {31'b0, up_addr_ok}, 32'd1);
    step();
    drive_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    sram_addr_ok = 1'b1;
    step();
    sram_addr_ok = 1'b0;

    // Flush with two in flight: both responses swallowed.
    flush = 1'b1;
    step();
    flush = 1'b0;
    respond(32'h0000_00BB, 1'b0, "flush_drop0");
    respond(32'h0000_00CC, 1'b0, "flush_drop1");
    // No accept in a flush cycle, even when idle.
    flush = 1'b1;
    drive_up(1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h0, 4'hF);
    #1 check_val("flush_no_accept", {31'b0, up_addr_ok}, 32'd0);
    step();
    flush = 1'b0;
    drive_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    #1 check_val("flush_no_hold", {31'b0, sram_req}, 32'd0);
    issue_load(32'h0000_5000);
    respond(32'h0000_0055, 1'b1, "post_flush_ld");

    // Flush coinciding with a response: only one more response to drop.
    issue_load(32'h0000_6000);
    issue_load(32'h0000_7000);
    flush = 1'b1;
    respond(32'h0000_0066, 1'b0, "flush_same_cyc");
    flush = 1'b0;
    respond(32'h0000_0077, 1'b0, "flush_same_drop");
    issue_load(32'h0000_8000);
    respond(32'h0000_0088, 1'b1, "flush_same_after");

    // A request on the bus is not withdrawn by flush, and its response is dropped.
    drive_up(1'b1, 1'b0, 2'd2, 32'h0000_9000, 32'h0, 4'hF);
    step();
    drive_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1 check_val("flush_keep_req", {31'b0, sram_req}, 32'd1);
    check_val("flush_keep_addr", sram_addr, 32'h0000_9000);
    sram_addr_ok = 1'b1;
    step();
    sram_addr_ok = 1'b0;
    respond(32'h0000_0099, 1'b0, "flush_onbus_drop");

    // Stray response with nothing in flight.
    check_val("perr_before", {31'b0, protocol_err}, 32'd0);
    respond(32'hFFFF_FFFF, 1'b0, "stray_resp");
    #1 check_val("perr_set", {31'b0, protocol_err}, 32'd1);
    repeat (3) step();
    #1 check_val("perr_sticky", {31'b0, protocol_err}, 32'd1);

    // Async reset while a request waits for addr_ok.
    drive_up(1'b1, 1'b0, 2'd2, 32'h0000_A000, 32'h0, 4'hF);
    step();
    drive_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    #1 check_val("areset_pre_req", {31'b0, sram_req}, 32'd1);
    reset = 1'b0;
    #1 check_val("areset_req", {31'b0, sram_req}, 32'd0);
    check_val("areset_perr", {31'b0, protocol_err}, 32'd0);
    step();
    reset = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
